// File: rtl/c3aibadapt_srrst_seq.sv
// rtl/c3aibadapt_srrst_seq.sv - ordered SR reset release sequencer (osc then div domain)
// Optional ack timeout flag enabled by defining C3AIBADAPT_SRRST_SEQ_TIMEOUT_EN.
module c3aibadapt_srrst_seq #(
  parameter int DLY_W = 8,
  parameter int TO_W  = 10
) (
  input  logic             sr_clock_osc_clk,
  input  logic             sr_reset_osc_clk_rst_n,
  input  logic             csr_rdy_dly_in,
  input  logic             dft_adpt_rst,
  input  logic             r_sr_free_run_div_clk,
  input  logic [DLY_W-1:0] r_sr_rst_dly,
  input  logic             sr_osc_rst_ack_n,
  input  logic             sr_div_rst_ack_n,
  output logic             sr_osc_rst_req_n,
  output logic             sr_div_rst_req_n,
  output logic             sr_rst_done,
  output logic             sr_rst_timeout,
  output logic [2:0]       sr_rst_state
);

  typedef enum logic [2:0] {
    HOLD    = 3'd0,
    DLY_OSC = 3'd1,
    REL_OSC = 3'd2,
    DLY_DIV = 3'd3,
    REL_DIV = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic             osc_req_q, osc_req_d;
  logic             div_req_q, div_req_d;
  logic             done_q, done_d;
  logic [1:0]       osc_sync_q, osc_sync_d;
  logic [1:0]       div_sync_q, div_sync_d;
  logic             go;
  logic             osc_ack;
  logic             div_ack;

  assign go      = csr_rdy_dly_in & ~dft_adpt_rst;
  assign osc_ack = osc_sync_q[1];
  assign div_ack = div_sync_q[1];

  always_comb begin
    osc_sync_d = {osc_sync_q[0], sr_osc_rst_ack_n};
    div_sync_d = {div_sync_q[0], sr_div_rst_ack_n};
  end

  // Losing go overrides every transition and collapses to HOLD in one edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    osc_req_d = osc_req_q;
    div_req_d = div_req_q;
    done_d    = 1'b0;
    if (!go) begin
      state_d   = HOLD;
      osc_req_d = 1'b0;
      div_req_d = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          osc_req_d = 1'b0;
          div_req_d = 1'b0;
          state_d   = DLY_OSC;
          cnt_d     = r_sr_rst_dly;
        end
        DLY_OSC: begin
          if (cnt_q == '0) begin
            state_d   = REL_OSC;
            osc_req_d = 1'b1;
          end else begin
            cnt_d = cnt_q - {{(DLY_W-1){1'b0}}, 1'b1};
          end
        end
        REL_OSC: begin
          if (osc_ack) begin
            if (r_sr_free_run_div_clk) begin
              div_req_d = 1'b1;
              state_d   = DONE;
            end else begin
              state_d = DLY_DIV;
              cnt_d   = r_sr_rst_dly;
            end
          end
        end
        DLY_DIV: begin
          if (cnt_q == '0) begin
            state_d   = REL_DIV;
            div_req_d = 1'b1;
          end else begin
            cnt_d = cnt_q - {{(DLY_W-1){1'b0}}, 1'b1};
          end
        end
        REL_DIV: begin
          if (div_ack) state_d = DONE;
        end
        DONE: begin
          done_d = 1'b1;
        end
        default: begin
          state_d   = HOLD;
          osc_req_d = 1'b0;
          div_req_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge sr_clock_osc_clk or negedge sr_reset_osc_clk_rst_n) begin
    if (!sr_reset_osc_clk_rst_n) begin
      state_q    <= HOLD;
      cnt_q      <= '0;
      osc_req_q  <= 1'b0;
      div_req_q  <= 1'b0;
      done_q     <= 1'b0;
      osc_sync_q <= 2'b00;
      div_sync_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      osc_req_q  <= osc_req_d;
      div_req_q  <= div_req_d;
      done_q     <= done_d;
      osc_sync_q <= osc_sync_d;
      div_sync_q <= div_sync_d;
    end
  end

`ifdef C3AIBADAPT_SRRST_SEQ_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            tmo_q, tmo_d;
  logic            rel_entry;
  logic            ack_wait;

  assign rel_entry = (state_d != state_q) && ((state_d == REL_OSC) || (state_d == REL_DIV));
  assign ack_wait  = go && (((state_q == REL_OSC) && !osc_ack) ||
                            ((state_q == REL_DIV) && !div_ack));

  // Counter saturates at all-ones; the flag never self-clears.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (rel_entry) begin
      to_cnt_d = '0;
    end else if (ack_wait && (to_cnt_q != {TO_W{1'b1}})) begin
      to_cnt_d = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
    end
    tmo_d = tmo_q | (to_cnt_d == {TO_W{1'b1}});
  end

  always_ff @(posedge sr_clock_osc_clk or negedge sr_reset_osc_clk_rst_n) begin
    if (!sr_reset_osc_clk_rst_n) begin
      to_cnt_q <= '0;
      tmo_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      tmo_q    <= tmo_d;
    end
  end

  assign sr_rst_timeout = tmo_q;
`else
  localparam logic TIMEOUT_TIE = (TO_W > 0) ? 1'b0 : 1'b0;
  assign sr_rst_timeout = TIMEOUT_TIE;
`endif

  assign sr_osc_rst_req_n = osc_req_q;
  assign sr_div_rst_req_n = div_req_q;
  assign sr_rst_done      = done_q;
  assign sr_rst_state     = state_q;

endmodule

// File: tb/tb_c3aibadapt_srrst_seq.sv
// tb/tb_c3aibadapt_srrst_seq.sv - scoreboard bench for c3aibadapt_srrst_seq
module tb_c3aibadapt_srrst_seq;

  logic       clk = 1'b0;
  logic       clk_en = 1'b1;
  logic       rst_n;
  logic       csr_rdy;
  logic       dft;
  logic       free_run;
  logic [7:0] dly;
  logic       osc_follow;
  logic       div_follow;
  logic       osc_ack_n;
  logic       div_ack_n;
  logic       osc_req_n;
  logic       div_req_n;
  logic       done;
  logic       tmo;
  logic [2:0] st;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [6:0] tup;
  } ev_t;

  ev_t        exp_q[$];
  logic [6:0] prev = 7'd0;

  c3aibadapt_srrst_seq #(.DLY_W(8), .TO_W(4)) dut (
    .sr_clock_osc_clk       (clk),
    .sr_reset_osc_clk_rst_n (rst_n),
    .csr_rdy_dly_in         (csr_rdy),
    .dft_adpt_rst           (dft),
    .r_sr_free_run_div_clk  (free_run),
    .r_sr_rst_dly           (dly),
    .sr_osc_rst_ack_n       (osc_ack_n),
    .sr_div_rst_ack_n       (div_ack_n),
    .sr_osc_rst_req_n       (osc_req_n),
    .sr_div_rst_req_n       (div_req_n),
    .sr_rst_done            (done),
    .sr_rst_timeout         (tmo),
    .sr_rst_state           (st)
  );

  // Feedback model: the synchronized reset comes back as soon as it is requested.
  assign osc_ack_n = osc_follow & osc_req_n;
  assign div_ack_n = div_follow & div_req_n;

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic expect_ev(input int c, input logic [2:0] s, input logic o,
                           input logic d, input logic dn, input logic t);
    ev_t e;
    e.cyc = c;
    e.tup = {s, o, d, dn, t};
    exp_q.push_back(e);
  endtask

  task automatic goto_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: any change of the output tuple must match the next queued event.
  always @(negedge clk) begin
    logic [6:0] cur;
    ev_t        e;
    cur = {st, osc_req_n, div_req_n, done, tmo};
    if (cur !== prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got %h at cycle %0d, nothing expected", cur, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.tup !== cur) begin
          errors++;
          $display("FAIL event: got %h at cycle %0d expected %h at cycle %0d",
                   cur, cyc, e.tup, e.cyc);
        end
      end
      prev = cur;
    end
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    rst_n      = 1'b1;
    csr_rdy    = 1'b0;
    dft        = 1'b0;
    free_run   = 1'b0;
    dly        = 8'd3;
    osc_follow = 1'b1;
    div_follow = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk("reset_outputs", {st, osc_req_n, div_req_n, done, tmo}, 7'd0);
    #1 rst_n = 1'b1;

    // Full ordered sequence, D=3; mid-count D change must be ignored.
    expect_ev(10, 3'd1, 0, 0, 0, 0);
    expect_ev(14, 3'd2, 1, 0, 0, 0);
    expect_ev(17, 3'd3, 1, 0, 0, 0);
    expect_ev(21, 3'd4, 1, 1, 0, 0);
    expect_ev(24, 3'd5, 1, 1, 0, 0);
    expect_ev(25, 3'd5, 1, 1, 1, 0);
    goto_cyc(9);  csr_rdy = 1'b1;
    goto_cyc(11); dly = 8'd7;
    goto_cyc(13); dly = 8'd3;

    // DFT pulse in DONE, restart, then csr_rdy lost in DLY_DIV with cnt=2.
    expect_ev(28, 3'd0, 0, 0, 0, 0);
    expect_ev(29, 3'd1, 0, 0, 0, 0);
    expect_ev(33, 3'd2, 1, 0, 0, 0);
    expect_ev(36, 3'd3, 1, 0, 0, 0);
    expect_ev(38, 3'd0, 0, 0, 0, 0);
    goto_cyc(27); dft = 1'b1;
    goto_cyc(28); dft = 1'b0;
    goto_cyc(37);
    chk("dly_div_state", {4'd0, st}, 7'd3);
    csr_rdy = 1'b0;

    // Free-run div clock with D=0: REL_OSC goes straight to DONE.
    expect_ev(45, 3'd1, 0, 0, 0, 0);
    expect_ev(46, 3'd2, 1, 0, 0, 0);
    expect_ev(49, 3'd5, 1, 1, 0, 0);
    expect_ev(50, 3'd5, 1, 1, 1, 0);
    expect_ev(53, 3'd0, 0, 0, 0, 0);
    goto_cyc(44); dly = 8'd0; free_run = 1'b1; csr_rdy = 1'b1;
    goto_cyc(52); csr_rdy = 1'b0;

    // Async reset in DLY_OSC while the clock is stopped, then a clean sequence.
    expect_ev(57, 3'd1, 0, 0, 0, 0);
    expect_ev(60, 3'd0, 0, 0, 0, 0);
    expect_ev(62, 3'd1, 0, 0, 0, 0);
    expect_ev(68, 3'd2, 1, 0, 0, 0);
    expect_ev(71, 3'd3, 1, 0, 0, 0);
    expect_ev(77, 3'd4, 1, 1, 0, 0);
    expect_ev(80, 3'd5, 1, 1, 0, 0);
    expect_ev(81, 3'd5, 1, 1, 1, 0);
    goto_cyc(56); dly = 8'd5; free_run = 1'b0; csr_rdy = 1'b1;
    goto_cyc(59);
    clk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("async_reset_no_clk", {st, osc_req_n, div_req_n, done, tmo}, 7'd0);
    #20 clk_en = 1'b1;
    goto_cyc(61); rst_n = 1'b1;

`ifdef C3AIBADAPT_SRRST_SEQ_TIMEOUT_EN
    // Stuck osc ack: timeout after 15 waiting cycles, sticky until rst_n.
    expect_ev(84,  3'd0, 0, 0, 0, 0);
    expect_ev(88,  3'd1, 0, 0, 0, 0);
    expect_ev(89,  3'd2, 1, 0, 0, 0);
    expect_ev(104, 3'd2, 1, 0, 0, 1);
    expect_ev(107, 3'd0, 0, 0, 0, 1);
    expect_ev(110, 3'd1, 0, 0, 0, 1);
    expect_ev(111, 3'd2, 1, 0, 0, 1);
    expect_ev(114, 3'd3, 1, 0, 0, 1);
    expect_ev(115, 3'd4, 1, 1, 0, 1);
    expect_ev(118, 3'd5, 1, 1, 0, 1);
    expect_ev(119, 3'd5, 1, 1, 1, 1);
    expect_ev(122, 3'd0, 0, 0, 0, 0);
    goto_cyc(83);  csr_rdy = 1'b0;
    goto_cyc(87);  dly = 8'd0; osc_follow = 1'b0; csr_rdy = 1'b1;
    goto_cyc(106); csr_rdy = 1'b0; osc_follow = 1'b1;
    goto_cyc(109); csr_rdy = 1'b1;
    goto_cyc(121); csr_rdy = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("timeout_cleared_by_rst", {6'd0, tmo}, 7'd0);
    goto_cyc(122); rst_n = 1'b1;
`else
    goto_cyc(90);
    chk("timeout_tied_low", {6'd0, tmo}, 7'd0);
`endif

    goto_cyc(cyc + 4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: %0d expected events never observed, first at cycle %0d",
               exp_q.size(), exp_q[0].cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
